// File: rtl/bfm_ahbmaster_cmd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bfm_ahbmaster_cmd
// Purpose  : AHB-Lite single-transfer master stage. Takes one read/write
//            command at a time on a valid/ready port, runs one NONSEQ SINGLE
//            transfer (address phase, then data phase) and returns read data
//            and error status on a valid/ready response port.
// Options  : BFM_AHBM_TIMEOUT_EN - when defined, an 8-bit wait counter aborts
//            an ADDR or DATA phase after TIMEOUT cycles of HREADY low.
// Revision : 1.0 - initial release
// ============================================================================
module bfm_ahbmaster_cmd #(
  parameter int         AWIDTH  = 10,
  parameter logic [3:0] HPROT_V = 4'h3,
  parameter int         TIMEOUT = 64
) (
  input  logic              HCLK,
  input  logic              HRESET,
  // command port
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_WRITE,
  input  logic [AWIDTH-1:0] CMD_ADDR,
  input  logic [2:0]        CMD_SIZE,
  input  logic [31:0]       CMD_WDATA,
  // response port
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_RDATA,
  output logic              RSP_ERROR,
  // AHB-Lite master outputs
  output logic [AWIDTH-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HBURST,
  output logic              HMASTLOCK,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  // AHB-Lite master inputs
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_ADDR = 2'd1;
  localparam logic [1:0] c_ST_DATA = 2'd2;
  localparam logic [1:0] c_ST_RESP = 2'd3;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] c_HBURST_SINGLE = 3'b000;

  logic [1:0]        r_state;
  logic [1:0]        w_next;

  logic [AWIDTH-1:0] r_haddr;
  logic              r_hwrite;
  logic [2:0]        r_hsize;
  logic [31:0]       r_wdata;

  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_error;

  logic              w_accept;
  logic              w_misalign;
  logic              w_illegal;
  logic              w_timeout;

  assign w_accept = CMD_VALID && CMD_READY;

  // Alignment of the byte address to the requested transfer size
  always_comb begin
    w_misalign = 1'b0;
    case (CMD_SIZE)
      3'd1:    w_misalign = CMD_ADDR[0];
      3'd2:    w_misalign = |CMD_ADDR[1:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_illegal = (CMD_SIZE > 3'd2) || w_misalign;

`ifdef BFM_AHBM_TIMEOUT_EN
  localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_wait_cnt;

  // Wait counter: cleared on every state change, counts HREADY-low cycles in ADDR/DATA
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state != w_next) begin
      r_wait_cnt <= 8'd0;
    end else if (((r_state == c_ST_ADDR) || (r_state == c_ST_DATA)) && !HREADY) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  // The last permitted wait cycle ends the phase with an error instead of waiting on
  assign w_timeout = ((r_state == c_ST_ADDR) || (r_state == c_ST_DATA)) &&
                     !HREADY && (r_wait_cnt == c_WAIT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_next = w_illegal ? c_ST_RESP : c_ST_ADDR;
        end
      end
      c_ST_ADDR: begin
        if (HREADY) begin
          w_next = c_ST_DATA;
        end else if (w_timeout) begin
          w_next = c_ST_RESP;
        end
      end
      c_ST_DATA: begin
        if (HREADY || w_timeout) begin
          w_next = c_ST_RESP;
        end
      end
      c_ST_RESP: begin
        if (RSP_READY) begin
          w_next = c_ST_IDLE;
        end
      end
      default: w_next = c_ST_IDLE;
    endcase
  end

  // State-derived outputs; command port is closed while reset is asserted
  always_comb begin
    CMD_READY = (r_state == c_ST_IDLE) && !HRESET;
    RSP_VALID = (r_state == c_ST_RESP);
    HTRANS    = (r_state == c_ST_ADDR) ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
    HWDATA    = ((r_state == c_ST_DATA) && r_hwrite) ? r_wdata : 32'd0;
  end

  // Address-phase controls, loaded only for legal commands and held afterwards
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= 3'd0;
      r_wdata  <= 32'd0;
    end else if (w_accept && !w_illegal) begin
      r_haddr  <= CMD_ADDR;
      r_hwrite <= CMD_WRITE;
      r_hsize  <= CMD_SIZE;
      r_wdata  <= CMD_WDATA;
    end
  end

  // Response registers: filled on completion/rejection, cleared once consumed
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_rsp_rdata <= 32'd0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_accept && w_illegal) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b1;
          end
        end
        c_ST_ADDR: begin
          if (!HREADY && w_timeout) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b1;
          end
        end
        c_ST_DATA: begin
          if (HREADY) begin
            r_rsp_rdata <= (!r_hwrite && !HRESP) ? HRDATA : 32'd0;
            r_rsp_error <= HRESP;
          end else if (w_timeout) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b1;
          end
        end
        c_ST_RESP: begin
          if (RSP_READY) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
          end
        end
        default: begin
          r_rsp_rdata <= 32'd0;
          r_rsp_error <= 1'b0;
        end
      endcase
    end
  end

  assign RSP_RDATA = r_rsp_rdata;
  assign RSP_ERROR = r_rsp_error;

  assign HADDR     = r_haddr;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = r_hsize;
  assign HBURST    = c_HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_V;

endmodule
`default_nettype wire
